// File: rtl/tlb_pkg.sv
// Shared TLB definitions: FSM state encoding, packed entry layout and width helpers.
// Entry layout (LSB first): W | PPN | VPN | ASID | VALID.
package tlb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_RESP = 2'd2
    } tlb_state_e;

    localparam int F_W   = 0;
    localparam int F_PPN = 1;

    function automatic int vpn_width(input int va_width, input int page_bits);
        return va_width - page_bits;
    endfunction

    function automatic int off_vpn(input int ppn_w);
        return F_PPN + ppn_w;
    endfunction

    function automatic int off_asid(input int ppn_w, input int vpn_w);
        return off_vpn(ppn_w) + vpn_w;
    endfunction

    function automatic int off_valid(input int ppn_w, input int vpn_w, input int asid_w);
        return off_asid(ppn_w, vpn_w) + asid_w;
    endfunction

    function automatic int entry_width(input int ppn_w, input int vpn_w, input int asid_w);
        return off_valid(ppn_w, vpn_w, asid_w) + 1;
    endfunction

endpackage

// File: rtl/tlb_victim_sel.sv
// Refill victim choice: lowest-index invalid entry, else a round-robin pointer.
// Combinational select; the pointer advances only on an install that used it.
module tlb_victim_sel #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ENTRIES-1:0] valid_i,
    input  logic               install_i,
    output logic [IDX_W-1:0]   victim_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        victim_o = free_found ? free_idx : ptr_q;
        // ENTRIES is a power of two, so natural overflow is the modulo wrap
        ptr_d    = (install_i && !free_found) ? ptr_q + IDX_W'(1) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/tlb_assoc.sv
// Fully-associative ASID-tagged TLB with walker refill; hit/bypass answers 1 cycle after accept, miss 1 cycle after walk_done.
// One request in flight (req_ready only in S_IDLE); TLB_PERF_COUNTERS_EN adds hit/miss counters.
module tlb_assoc
    import tlb_pkg::*;
#(
    parameter int ENTRIES    = 8,
    parameter int VA_WIDTH   = 32,
    parameter int PA_WIDTH   = 32,
    parameter int PAGE_BITS  = 12,
    parameter int ASID_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           vm_enable,
    input  logic                           flush,
    input  logic                           flush_asid_en,
    input  logic [ASID_WIDTH-1:0]          flush_asid,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [VA_WIDTH-1:0]            req_vaddr,
    input  logic [ASID_WIDTH-1:0]          req_asid,
    input  logic                           req_store,
    output logic                           resp_valid,
    output logic [PA_WIDTH-1:0]            resp_paddr,
    output logic                           resp_hit,
    output logic                           resp_fault,
    output logic                           walk_req,
    output logic [VA_WIDTH-PAGE_BITS-1:0]  walk_vpn,
    output logic [ASID_WIDTH-1:0]          walk_asid,
    input  logic                           walk_done,
    input  logic [PA_WIDTH-PAGE_BITS-1:0]  walk_ppn,
    input  logic                           walk_w,
`ifdef TLB_PERF_COUNTERS_EN
    output logic [31:0]                    perf_hits,
    output logic [31:0]                    perf_misses,
`endif
    input  logic                           walk_fault
);

    localparam int VPN_W     = vpn_width(VA_WIDTH, PAGE_BITS);
    localparam int PPN_W     = PA_WIDTH - PAGE_BITS;
    localparam int IDX_W     = $clog2(ENTRIES);
    localparam int OFF_VPN   = off_vpn(PPN_W);
    localparam int OFF_ASID  = off_asid(PPN_W, VPN_W);
    localparam int OFF_VALID = off_valid(PPN_W, VPN_W, ASID_WIDTH);
    localparam int ENT_W     = entry_width(PPN_W, VPN_W, ASID_WIDTH);

    tlb_state_e               state_q, state_d;
    logic [VA_WIDTH-1:0]      vaddr_q, vaddr_d;
    logic [ASID_WIDTH-1:0]    asid_q, asid_d;
    logic                     store_q, store_d;
    logic                     drop_q, drop_d;
    logic [PA_WIDTH-1:0]      paddr_q, paddr_d;
    logic                     hit_q, hit_d;
    logic                     fault_q, fault_d;
    logic [ENT_W-1:0]         ent_q [ENTRIES];

    logic [ENTRIES-1:0]       valid_vec;
    logic [VPN_W-1:0]         req_vpn;
    logic                     lk_hit;
    logic [IDX_W-1:0]         lk_idx;
    logic [IDX_W-1:0]         victim;
    logic                     flush_any;
    logic                     accept;
    logic                     install;

    assign req_vpn   = req_vaddr[VA_WIDTH-1:PAGE_BITS];
    assign flush_any = flush | flush_asid_en;
    assign accept    = req_valid && req_ready;
    // A flush in flight or on this edge suppresses the install but not the response
    assign install   = (state_q == S_WALK) && walk_done && !walk_fault && !drop_q && !flush_any;

    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            valid_vec[i] = ent_q[i][OFF_VALID];
            if (ent_q[i][OFF_VALID] && ent_q[i][OFF_VPN +: VPN_W] == req_vpn &&
                ent_q[i][OFF_ASID +: ASID_WIDTH] == req_asid) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
        end
    end

    tlb_victim_sel #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_victim_sel (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_vec),
        .install_i (install),
        .victim_o  (victim)
    );

    always_comb begin
        state_d = state_q;
        vaddr_d = vaddr_q;
        asid_d  = asid_q;
        store_d = store_q;
        drop_d  = drop_q;
        paddr_d = paddr_q;
        hit_d   = hit_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    vaddr_d = req_vaddr;
                    asid_d  = req_asid;
                    store_d = req_store;
                    drop_d  = 1'b0;
                    if (!vm_enable) begin
                        state_d = S_RESP;
                        paddr_d = PA_WIDTH'(req_vaddr);
                        hit_d   = 1'b1;
                        fault_d = 1'b0;
                    end else if (lk_hit) begin
                        state_d = S_RESP;
                        paddr_d = {ent_q[lk_idx][F_PPN +: PPN_W], req_vaddr[PAGE_BITS-1:0]};
                        hit_d   = 1'b1;
                        fault_d = req_store && !ent_q[lk_idx][F_W];
                    end else begin
                        state_d = S_WALK;
                    end
                end
            end
            S_WALK: begin
                if (flush_any) drop_d = 1'b1;
                if (walk_done) begin
                    state_d = S_RESP;
                    hit_d   = 1'b0;
                    if (walk_fault) begin
                        paddr_d = '0;
                        fault_d = 1'b1;
                    end else begin
                        paddr_d = {walk_ppn, vaddr_q[PAGE_BITS-1:0]};
                        fault_d = store_q && !walk_w;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            vaddr_q <= '0;
            asid_q  <= '0;
            store_q <= 1'b0;
            drop_q  <= 1'b0;
            paddr_q <= '0;
            hit_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vaddr_q <= vaddr_d;
            asid_q  <= asid_d;
            store_q <= store_d;
            drop_q  <= drop_d;
            paddr_q <= paddr_d;
            hit_q   <= hit_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (reset) begin
                ent_q[i] <= '0;
            end else if (flush ||
                         (flush_asid_en && ent_q[i][OFF_ASID +: ASID_WIDTH] == flush_asid)) begin
                ent_q[i][OFF_VALID] <= 1'b0;
            end else if (install && victim == IDX_W'(i)) begin
                ent_q[i] <= {1'b1, asid_q, vaddr_q[VA_WIDTH-1:PAGE_BITS], walk_ppn, walk_w};
            end
        end
    end

`ifdef TLB_PERF_COUNTERS_EN
    logic [31:0] perf_hits_q, perf_misses_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
        end else if (accept && vm_enable) begin
            if (lk_hit) perf_hits_q   <= perf_hits_q + 32'd1;
            else        perf_misses_q <= perf_misses_q + 32'd1;
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
`endif

    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign resp_valid = (state_q == S_RESP);
    assign resp_paddr = paddr_q;
    assign resp_hit   = hit_q;
    assign resp_fault = fault_q;
    assign walk_req   = (state_q == S_WALK);
    assign walk_vpn   = vaddr_q[VA_WIDTH-1:PAGE_BITS];
    assign walk_asid  = asid_q;

endmodule

// File: tb/tb_tlb_assoc.sv
// Directed plus randomized bench for tlb_assoc against an array-based TLB reference model.
module tb_tlb_assoc;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vm_enable = 1'b0;
    logic        flush = 1'b0;
    logic        flush_asid_en = 1'b0;
    logic [3:0]  flush_asid = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_vaddr = '0;
    logic [3:0]  req_asid = '0;
    logic        req_store = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_paddr;
    logic        resp_hit;
    logic        resp_fault;
    logic        walk_req;
    logic [19:0] walk_vpn;
    logic [3:0]  walk_asid;
    logic        walk_done = 1'b0;
    logic [19:0] walk_ppn = '0;
    logic        walk_w = 1'b0;
    logic        walk_fault = 1'b0;
`ifdef TLB_PERF_COUNTERS_EN
    logic [31:0] perf_hits, perf_misses;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_valid [N];
    logic [3:0]  m_asid  [N];
    logic [19:0] m_vpn   [N];
    logic [19:0] m_ppn   [N];
    bit          m_w     [N];
    int          m_ptr;
    int          m_hits, m_misses;

    tlb_assoc dut (
        .clk (clk), .reset (reset), .vm_enable (vm_enable),
        .flush (flush), .flush_asid_en (flush_asid_en), .flush_asid (flush_asid),
        .req_valid (req_valid), .req_ready (req_ready), .req_vaddr (req_vaddr),
        .req_asid (req_asid), .req_store (req_store),
        .resp_valid (resp_valid), .resp_paddr (resp_paddr), .resp_hit (resp_hit),
        .resp_fault (resp_fault), .walk_req (walk_req), .walk_vpn (walk_vpn),
        .walk_asid (walk_asid), .walk_done (walk_done), .walk_ppn (walk_ppn),
        .walk_w (walk_w),
`ifdef TLB_PERF_COUNTERS_EN
        .perf_hits (perf_hits), .perf_misses (perf_misses),
`endif
        .walk_fault (walk_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_lookup(input logic [19:0] vpn, input logic [3:0] asid);
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_vpn[i] == vpn && m_asid[i] == asid) return i;
        return -1;
    endfunction

    task automatic m_install(input logic [19:0] vpn, input logic [3:0] asid,
                             input logic [19:0] ppn, input bit w);
        int slot = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
        if (slot < 0) begin
            slot  = m_ptr;
            m_ptr = (m_ptr + 1) % N;
        end
        m_valid[slot] = 1; m_asid[slot] = asid; m_vpn[slot] = vpn;
        m_ppn[slot] = ppn; m_w[slot] = w;
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_valid[i] = 0;
        m_ptr = 0; m_hits = 0; m_misses = 0;
    endtask

    // Called and returns at a negedge with the DUT idle.
    // fl_mode: 0 none, 1 flush one cycle inside the walk, 2 flush coincident with walk_done.
    task automatic do_req(input logic [31:0] va, input logic [3:0] asid, input bit st,
                          input bit vm, input logic [19:0] ppn, input bit w, input bit wf,
                          input int fl_mode, input int dly);
        int idx;
        logic [31:0] exp_pa;
        bit exp_fault;
        idx = vm ? m_lookup(va[31:12], asid) : -1;
        vm_enable = vm; req_valid = 1; req_vaddr = va; req_asid = asid; req_store = st;
        @(negedge clk);
        req_valid = 0;
        if (!vm || idx >= 0) begin
            if (!vm) begin
                exp_pa = va; exp_fault = 0;
            end else begin
                exp_pa = {m_ppn[idx], va[11:0]}; exp_fault = st && !m_w[idx];
                m_hits++;
            end
            check("hit_resp_valid", resp_valid, 1);
            check("hit_paddr", resp_paddr, exp_pa);
            check("hit_flag", resp_hit, 1);
            check("hit_fault", resp_fault, exp_fault);
            check("hit_no_walk", walk_req, 0);
        end else begin
            m_misses++;
            check("miss_walk_req", walk_req, 1);
            check("miss_walk_vpn", walk_vpn, va[31:12]);
            check("miss_walk_asid", walk_asid, asid);
            check("miss_no_resp", resp_valid, 0);
            if (fl_mode == 1) begin
                flush = 1;
                @(negedge clk);
                flush = 0;
            end
            repeat (dly) @(negedge clk);
            walk_done = 1; walk_ppn = ppn; walk_w = w; walk_fault = wf;
            if (fl_mode == 2) flush = 1;
            @(negedge clk);
            walk_done = 0; walk_fault = 0; flush = 0;
            if (fl_mode != 0) for (int i = 0; i < N; i++) m_valid[i] = 0;
            exp_pa    = wf ? 32'h0 : {ppn, va[11:0]};
            exp_fault = wf ? 1'b1 : (st && !w);
            check("miss_resp_valid", resp_valid, 1);
            check("miss_paddr", resp_paddr, exp_pa);
            check("miss_hit_flag", resp_hit, 0);
            check("miss_fault", resp_fault, exp_fault);
            if (!wf && fl_mode == 0) m_install(va[31:12], asid, ppn, w);
        end
        @(negedge clk);
        check("resp_one_cycle", resp_valid, 0);
        check("ready_again", req_ready, 1);
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_walk_req", walk_req, 0);
        check("rst_paddr", resp_paddr, 0);
        reset = 0;
        m_reset();
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);
    endtask

    task automatic do_flush_asid(input logic [3:0] a);
        flush_asid_en = 1; flush_asid = a;
        @(negedge clk);
        flush_asid_en = 0;
        for (int i = 0; i < N; i++) if (m_asid[i] == a) m_valid[i] = 0;
    endtask

    initial begin
        m_reset();
        // 1: reset state and bypass
        do_reset();
        do_req(32'h12345678, 4'd0, 0, 0, 20'h0, 0, 0, 0, 0);

        // 2: miss, refill, then hit
        do_req(32'h00401ABC, 4'd3, 0, 1, 20'h80020, 1, 0, 0, 2);
        do_req(32'h00401ABC, 4'd3, 0, 1, 20'h0, 0, 0, 0, 0);

        // 3: read-only page: store faults on hit, load does not
        do_req(32'h00777123, 4'd3, 0, 1, 20'h55555, 0, 0, 0, 0);
        do_req(32'h00777456, 4'd3, 1, 1, 20'h0, 0, 0, 0, 0);
        do_req(32'h00777789, 4'd3, 0, 1, 20'h0, 0, 0, 0, 0);

        // 4: fill, replace round-robin, wrap the pointer
        do_reset();
        for (int k = 0; k < N + 2 + N; k++)
            do_req({20'h10000 + 20'(k), 12'h010}, 4'd1, 0, 1, 20'hA0000 + 20'(k), 1, 0, 0, 0);
        for (int k = 0; k < N + 2 + N; k++)
            do_req({20'h10000 + 20'(k), 12'h020}, 4'd1, 0, 1, 20'hB0000 + 20'(k), 1, 0, 0, 1);

        // 5: selective flush, then flush inside a walk and coincident with walk_done
        do_reset();
        do_req(32'h00A00000, 4'd1, 0, 1, 20'h11111, 1, 0, 0, 0);
        do_req(32'h00B00000, 4'd2, 0, 1, 20'h22222, 1, 0, 0, 0);
        do_flush_asid(4'd1);
        do_req(32'h00A00004, 4'd1, 0, 1, 20'h33333, 1, 0, 0, 0);
        do_req(32'h00B00008, 4'd2, 0, 1, 20'h0, 0, 0, 0, 0);
        do_req(32'h00C00000, 4'd2, 0, 1, 20'h44444, 1, 0, 1, 1);
        do_req(32'h00C00000, 4'd2, 0, 1, 20'h45454, 1, 0, 2, 0);
        do_req(32'h00C00000, 4'd2, 0, 1, 20'h46464, 1, 0, 0, 0);
        do_req(32'h00C00000, 4'd2, 1, 1, 20'h0, 0, 0, 0, 0);

        // 6: walker fault installs nothing
        do_req(32'h00D00FFF, 4'd2, 0, 1, 20'h77777, 1, 1, 0, 0);
        do_req(32'h00D00FFF, 4'd2, 0, 1, 20'h78787, 0, 0, 0, 0);

        // Reset during a walk; a late walk_done must be ignored
        vm_enable = 1; req_valid = 1; req_vaddr = 32'h00E00000; req_asid = 4'd5; req_store = 0;
        @(negedge clk);
        req_valid = 0;
        check("mw_walk_req", walk_req, 1);
        reset = 1;
        @(negedge clk);
        check("mw_walk_dropped", walk_req, 0);
        reset = 0; walk_done = 1; walk_ppn = 20'h99999;
        @(negedge clk);
        walk_done = 0;
        m_reset();
        check("mw_no_resp", resp_valid, 0);
        check("mw_ready", req_ready, 1);
        do_req(32'h00E00000, 4'd5, 0, 1, 20'h9A9A9, 1, 0, 0, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 200; n++) begin
            logic [31:0] va;
            va = {20'h00100 + 20'($urandom_range(0, 11)), 12'($urandom)};
            if ($urandom_range(0, 19) == 0) do_flush_asid(4'($urandom_range(0, 2)));
            do_req(va, 4'($urandom_range(0, 2)), 1'($urandom), $urandom_range(0, 9) != 0,
                   20'($urandom), 1'($urandom), $urandom_range(0, 9) == 0,
                   ($urandom_range(0, 14) == 0) ? 1 : 0, $urandom_range(0, 3));
        end

`ifdef TLB_PERF_COUNTERS_EN
        check("perf_hits", perf_hits, 32'(m_hits));
        check("perf_misses", perf_misses, 32'(m_misses));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
